// File: rtl/line_buf_ctrl_pkg.sv
// Shared definitions for the display line-buffer ping-pong controller:
// bank ownership states, read FSM states, geometry and RGB field slices.
package line_buf_ctrl_pkg;

    localparam int LBC_PIX_PER_LINE = 100;
    localparam int LBC_AW           = 7;
    localparam int LBC_DW           = 24;

    // RGB field positions inside one pixel word
    localparam int PIX_R_HI = 23;
    localparam int PIX_R_LO = 16;
    localparam int PIX_G_HI = 15;
    localparam int PIX_G_LO = 8;
    localparam int PIX_B_HI = 7;
    localparam int PIX_B_LO = 0;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rd_state_t;

    // A bank may take host pixels only while it is not owned by the reader
    function automatic logic bank_writable(input bank_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

endpackage

// File: rtl/lbc_bank_tracker.sv
// Ownership state of one line bank. The writer moves it EMPTY->FILLING->FULL,
// the reader moves it FULL->DRAINING->EMPTY, so a bank is never written and
// read at the same time.
module lbc_bank_tracker
    import line_buf_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        rst_n,
    input  logic        fill_start,
    input  logic        fill_done,
    input  logic        drain_start,
    input  logic        drain_done,
    output bank_state_t state
);

    // Bank ownership transitions; each owner can only advance its own phases
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (fill_done) begin
                        state <= FULL;
                    end else if (fill_start) begin
                        state <= FILLING;
                    end else begin
                        state <= EMPTY;
                    end
                end
                FILLING: begin
                    if (fill_done) begin
                        state <= FULL;
                    end else begin
                        state <= FILLING;
                    end
                end
                FULL: begin
                    if (drain_start) begin
                        state <= DRAINING;
                    end else begin
                        state <= FULL;
                    end
                end
                DRAINING: begin
                    if (drain_done) begin
                        state <= EMPTY;
                    end else begin
                        state <= DRAINING;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Ping-pong controller for two display line buffers. The host fills one bank
// through a valid/ready handshake while the other bank drains one pixel per
// cycle on each line request. Build option LBC_STATS_EN adds underrun and
// completed-line counters.
module line_buf_ctrl
    import line_buf_ctrl_pkg::*;
#(
    parameter int PIX_PER_LINE = LBC_PIX_PER_LINE,
    parameter int AW           = LBC_AW,
    parameter int DW           = LBC_DW
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          line_req,
    output logic          WE0,
    output logic          WE1,
    output logic [AW-1:0] WAddr,
    output logic [DW-1:0] WData,
    output logic          RE0,
    output logic          RE1,
    output logic [AW-1:0] RAddr,
    output logic          pix_valid,
    output logic          line_done,
    output logic          underrun,
    output logic [AW-1:0] row
`ifdef LBC_STATS_EN
    ,
    output logic [15:0]   underrun_cnt,
    output logic [15:0]   lines_cnt
`endif
);

    localparam logic [AW-1:0] LAST_IDX = AW'(PIX_PER_LINE - 1);

    bank_state_t   bank_state_s [2];
    logic          wbank_r;
    logic          rbank_r;
    logic [AW-1:0] wcnt_r;
    logic [AW-1:0] rcnt_r;
    rd_state_t     rd_state_r;

    logic          wr_ready_s;
    logic          accept_s;
    logic          underrun_evt_s;
    logic          line_evt_s;
    logic [1:0]    fill_start_s;
    logic [1:0]    fill_done_s;
    logic [1:0]    drain_start_s;
    logic [1:0]    drain_done_s;

    // Handshake, event decode and per-bank transition requests
    always_comb begin
        wr_ready_s     = rst_n & bank_writable(bank_state_s[wbank_r]);
        accept_s       = wr_valid & wr_ready_s;
        underrun_evt_s = 1'b0;
        if ((rd_state_r == IDLE) && line_req && (bank_state_s[rbank_r] != FULL)) begin
            underrun_evt_s = 1'b1;
        end else begin
            underrun_evt_s = 1'b0;
        end
        line_evt_s = (RE0 | RE1) && (RAddr == LAST_IDX);
        for (int b = 0; b < 2; b++) begin
            fill_start_s[b]  = accept_s && (wbank_r == 1'(b)) && (bank_state_s[b] == EMPTY);
            fill_done_s[b]   = accept_s && (wbank_r == 1'(b)) && (wcnt_r == LAST_IDX);
            drain_start_s[b] = (rd_state_r == IDLE) && line_req && (rbank_r == 1'(b))
                               && (bank_state_s[b] == FULL);
            drain_done_s[b]  = (rd_state_r == DRAIN) && (rbank_r == 1'(b)) && (rcnt_r == LAST_IDX);
        end
    end

    assign wr_ready = wr_ready_s;

    lbc_bank_tracker u_bank0 (
        .clock       (clock),
        .rst_n       (rst_n),
        .fill_start  (fill_start_s[0]),
        .fill_done   (fill_done_s[0]),
        .drain_start (drain_start_s[0]),
        .drain_done  (drain_done_s[0]),
        .state       (bank_state_s[0])
    );

    lbc_bank_tracker u_bank1 (
        .clock       (clock),
        .rst_n       (rst_n),
        .fill_start  (fill_start_s[1]),
        .fill_done   (fill_done_s[1]),
        .drain_start (drain_start_s[1]),
        .drain_done  (drain_done_s[1]),
        .state       (bank_state_s[1])
    );

    // Write side: register strobe/address/data one cycle after acceptance
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            WE0     <= 1'b0;
            WE1     <= 1'b0;
            WAddr   <= {AW{1'b0}};
            WData   <= {DW{1'b0}};
            wcnt_r  <= {AW{1'b0}};
            wbank_r <= 1'b0;
        end else begin
            WE0 <= accept_s & ~wbank_r;
            WE1 <= accept_s & wbank_r;
            if (accept_s) begin
                WData <= wr_data;
                WAddr <= wcnt_r;
                if (wcnt_r == LAST_IDX) begin
                    wcnt_r  <= {AW{1'b0}};
                    wbank_r <= ~wbank_r;
                end else begin
                    wcnt_r <= wcnt_r + AW'(1);
                end
            end
        end
    end

    // Read FSM: start a drain on a request for a full bank, else flag underrun
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_r <= IDLE;
            rbank_r    <= 1'b0;
            rcnt_r     <= {AW{1'b0}};
            RE0        <= 1'b0;
            RE1        <= 1'b0;
            RAddr      <= {AW{1'b0}};
            underrun   <= 1'b0;
        end else begin
            RE0      <= 1'b0;
            RE1      <= 1'b0;
            underrun <= 1'b0;
            case (rd_state_r)
                IDLE: begin
                    if (line_req) begin
                        if (bank_state_s[rbank_r] == FULL) begin
                            rd_state_r <= DRAIN;
                            rcnt_r     <= {AW{1'b0}};
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    RE0   <= ~rbank_r;
                    RE1   <= rbank_r;
                    RAddr <= rcnt_r;
                    if (rcnt_r == LAST_IDX) begin
                        rcnt_r     <= {AW{1'b0}};
                        rbank_r    <= ~rbank_r;
                        rd_state_r <= IDLE;
                    end else begin
                        rcnt_r <= rcnt_r + AW'(1);
                    end
                end
                default: rd_state_r <= IDLE;
            endcase
        end
    end

    // Bank read data arrives one cycle after RE; mirror that in valid/row
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            line_done <= 1'b0;
            row       <= {AW{1'b0}};
        end else begin
            pix_valid <= RE0 | RE1;
            line_done <= line_evt_s;
            row       <= RAddr;
        end
    end

`ifdef LBC_STATS_EN
    // Statistics: saturating underrun count, wrapping completed-line count
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= 16'h0000;
            lines_cnt    <= 16'h0000;
        end else begin
            if (underrun_evt_s && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'h0001;
            end
            if (line_evt_s) begin
                lines_cnt <= lines_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: directed step table, a hand-written stall/drain
// sequence, randomized traffic against a line-level reference model, and a
// reset in the middle of a drain. Build with LBC_STATS_EN to cover counters.
module tb_line_buf_ctrl;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [23:0] wr_data;
    logic        wr_ready;
    logic        line_req;
    logic        WE0, WE1, RE0, RE1;
    logic [6:0]  WAddr, RAddr, row;
    logic [23:0] WData;
    logic        pix_valid, line_done, underrun;
`ifdef LBC_STATS_EN
    logic [15:0] underrun_cnt, lines_cnt;
`endif

    line_buf_ctrl dut (
        .clock(clock), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .line_req(line_req), .WE0(WE0), .WE1(WE1),
        .WAddr(WAddr), .WData(WData), .RE0(RE0), .RE1(RE1), .RAddr(RAddr),
        .pix_valid(pix_valid), .line_done(line_done), .underrun(underrun), .row(row)
`ifdef LBC_STATS_EN
        , .underrun_cnt(underrun_cnt), .lines_cnt(lines_cnt)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model (line/pixel level) ----------------
    int          m_fill [2];          // pixels currently held by each bank
    bit          m_wb, m_rb;          // bank being filled / next bank to send
    int          m_left, m_rpos;      // pixels still to send in the active line
    logic [23:0] m_mem [2][100];
    logic [23:0] pend_pix;
    bit          e_rdy, e_we0, e_we1, e_re0, e_re1, e_pv, e_ld, e_ur;
    logic [6:0]  e_waddr, e_raddr, e_row;
    logic [23:0] e_wdata, e_pix;
    logic [15:0] e_urcnt, e_lines;

    function automatic void model_reset();
        m_fill[0] = 0; m_fill[1] = 0; m_wb = 0; m_rb = 0; m_left = 0; m_rpos = 0;
        pend_pix = 24'h0; e_rdy = 1; e_we0 = 0; e_we1 = 0; e_re0 = 0; e_re1 = 0;
        e_pv = 0; e_ld = 0; e_ur = 0; e_waddr = 7'd0; e_raddr = 7'd0; e_row = 7'd0;
        e_wdata = 24'h0; e_pix = 24'h0; e_urcnt = 16'h0; e_lines = 16'h0;
    endfunction

    function automatic void model_step(bit v, logic [23:0] d, bit req);
        bit prev_re, acc, idle, rb_full;
        prev_re = e_re0 | e_re1;
        e_pv  = prev_re;
        e_ld  = prev_re && (e_raddr == 7'd99);
        e_row = e_raddr;
        e_pix = pend_pix;
        if (e_ld) e_lines = e_lines + 16'd1;
        acc     = v && (m_fill[m_wb] < 100);
        idle    = (m_left == 0);
        rb_full = (m_fill[m_rb] == 100);
        e_we0 = 0; e_we1 = 0;
        if (acc) begin
            if (m_wb == 1'b0) e_we0 = 1; else e_we1 = 1;
            e_waddr = 7'(m_fill[m_wb]);
            e_wdata = d;
            m_mem[m_wb][m_fill[m_wb]] = d;
            m_fill[m_wb]++;
            if (m_fill[m_wb] == 100) m_wb = ~m_wb;
        end
        e_re0 = 0; e_re1 = 0; e_ur = 0;
        if (!idle) begin
            if (m_rb == 1'b0) e_re0 = 1; else e_re1 = 1;
            e_raddr  = 7'(m_rpos);
            pend_pix = m_mem[m_rb][m_rpos];
            m_rpos++;
            m_left--;
            if (m_left == 0) begin
                m_fill[m_rb] = 0;
                m_rb = ~m_rb;
            end
        end else if (req) begin
            if (rb_full) begin
                m_left = 100;
                m_rpos = 0;
            end else begin
                e_ur = 1;
                if (e_urcnt != 16'hFFFF) e_urcnt = e_urcnt + 16'd1;
            end
        end
        e_rdy = (m_fill[m_wb] < 100);
    endfunction

    function automatic logic [52:0] dut_vec();
        return {wr_ready, WE0, WE1, WAddr, WData, RE0, RE1, RAddr, pix_valid, line_done, underrun, row};
    endfunction

    function automatic logic [52:0] exp_vec();
        return {e_rdy, e_we0, e_we1, e_waddr, e_wdata, e_re0, e_re1, e_raddr, e_pv, e_ld, e_ur, e_row};
    endfunction

    // bench-side bank memories driven by the DUT strobes
    logic [23:0] ram [2][128];
    logic [23:0] rd_q;
    int c_we0, c_we1, c_re0, c_re1, c_ur, c_ld;

    task automatic clr_counts();
        c_we0 = 0; c_we1 = 0; c_re0 = 0; c_re1 = 0; c_ur = 0; c_ld = 0;
    endtask

    task automatic tick(input bit v, input logic [23:0] d, input bit req, output bit acc);
        wr_valid = v; wr_data = d; line_req = req;
        acc = v && wr_ready;
        @(posedge clock);
        model_step(v, d, req);
        #1;
        cyc++;
        check($sformatf("outputs@%0d", cyc), 64'(dut_vec()), 64'(exp_vec()));
`ifdef LBC_STATS_EN
        check($sformatf("stats@%0d", cyc), {32'h0, underrun_cnt, lines_cnt}, {32'h0, e_urcnt, e_lines});
`endif
        if (pix_valid) check($sformatf("pixel@%0d", cyc), 64'(rd_q), 64'(e_pix));
        if (RE0) rd_q = ram[0][RAddr];
        if (RE1) rd_q = ram[1][RAddr];
        if (WE0) ram[0][WAddr] = WData;
        if (WE1) ram[1][WAddr] = WData;
        c_we0 += int'(WE0); c_we1 += int'(WE1); c_re0 += int'(RE0); c_re1 += int'(RE1);
        c_ur += int'(underrun); c_ld += int'(line_done);
    endtask

    typedef struct {
        string name;
        int npix; bit req; int req2; int cycles;
        int we0, we1, re0, re1, ur, ld; bit rdy;
    } step_t;
    step_t steps[$];

    task automatic add_step(string name, int npix, bit req, int req2, int cycles,
                            int we0, int we1, int re0, int re1, int ur, int ld, bit rdy);
        step_t s;
        s.name = name; s.npix = npix; s.req = req; s.req2 = req2; s.cycles = cycles;
        s.we0 = we0; s.we1 = we1; s.re0 = re0; s.re1 = re1; s.ur = ur; s.ld = ld; s.rdy = rdy;
        steps.push_back(s);
    endtask

    logic [23:0] pixctr;

    task automatic run_stall();
        bit acc, done;
        int acc_k, n_acc;
        n_acc = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, pixctr, 1'b0, acc);
            n_acc += int'(acc);
        end
        check("stall_no_accept", 64'(n_acc), 64'd0);
        clr_counts();
        done = 0; acc_k = -1;
        for (int k = 0; k < 120; k++) begin
            tick(!done, pixctr, (k == 0), acc);
            if (acc && !done) begin
                done = 1; acc_k = k; pixctr = pixctr + 24'd1;
            end
        end
        check("stall_accept_cycle", 64'(acc_k), 64'd101);
        check("stall_we0", 64'(c_we0), 64'd1);
        check("stall_re0", 64'(c_re0), 64'd100);
        check("stall_line_done", 64'(c_ld), 64'd1);
    endtask

    initial begin
        bit acc;
        int sent;
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = 24'h0; line_req = 1'b0;
        rd_q = 24'h0; pixctr = 24'h000001;
        model_reset();
        clr_counts();
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 64'(dut_vec()), 64'd0);
        #2 rst_n = 1'b1;
        #1 check("ready_after_reset", 64'(wr_ready), 64'd1);

        add_step("urun_empty",    0, 1, -1,   4,   0,   0,   0,   0, 1, 0, 1);
        add_step("fill_bank0",  100, 0, -1, 103, 100,   0,   0,   0, 0, 0, 1);
        add_step("fill_bank1",  100, 0, -1, 103,   0, 100,   0,   0, 0, 0, 0);
        add_step("drain1_fill0", 99, 1, -1, 110,  99,   0,   0, 100, 0, 1, 1);
        add_step("drain0_fill1",100, 1, -1, 110,   0, 100, 100,   0, 0, 1, 1);
        add_step("drain1_ignore", 0, 1, 50, 110,   0,   0,   0, 100, 0, 1, 1);
        add_step("urun_again",    0, 1, -1,   4,   0,   0,   0,   0, 1, 0, 1);

        for (int i = 0; i < steps.size(); i++) begin
            if (i == 3) run_stall();
            clr_counts();
            sent = 0;
            for (int k = 0; k < steps[i].cycles; k++) begin
                tick(sent < steps[i].npix, pixctr,
                     (steps[i].req && k == 0) || (k == steps[i].req2), acc);
                if (acc) begin
                    sent++; pixctr = pixctr + 24'd1;
                end
            end
            check({steps[i].name, "_we0"}, 64'(c_we0), 64'(steps[i].we0));
            check({steps[i].name, "_we1"}, 64'(c_we1), 64'(steps[i].we1));
            check({steps[i].name, "_re0"}, 64'(c_re0), 64'(steps[i].re0));
            check({steps[i].name, "_re1"}, 64'(c_re1), 64'(steps[i].re1));
            check({steps[i].name, "_underrun"}, 64'(c_ur), 64'(steps[i].ur));
            check({steps[i].name, "_line_done"}, 64'(c_ld), 64'(steps[i].ld));
            check({steps[i].name, "_ready"}, 64'(wr_ready), 64'(steps[i].rdy));
`ifdef LBC_STATS_EN
            if (i == 0) check("underrun_cnt_once", 64'(underrun_cnt), 64'd1);
`endif
        end

        // randomized traffic checked every cycle by the model
        for (int k = 0; k < 4000; k++) begin
            tick($urandom_range(0, 9) < 7, 24'($urandom), $urandom_range(0, 39) == 0, acc);
        end

        // reset from an arbitrary state, then fill one line and reset mid-drain
        rst_n = 1'b0;
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        sent = 0;
        for (int k = 0; k < 200 && sent < 100; k++) begin
            tick(1'b1, pixctr, 1'b0, acc);
            if (acc) begin
                sent++; pixctr = pixctr + 24'd1;
            end
        end
        check("refill_count", 64'(sent), 64'd100);
        tick(1'b0, 24'h0, 1'b1, acc);
        for (int k = 0; k < 50; k++) tick(1'b0, 24'h0, 1'b0, acc);
        check("mid_drain_raddr", 64'(RAddr), 64'd49);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 64'(dut_vec()), 64'd0);
`ifdef LBC_STATS_EN
        check("async_reset_stats", {32'h0, underrun_cnt, lines_cnt}, 64'd0);
`endif
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        #1 check("ready_after_release", 64'(wr_ready), 64'd1);
        tick(1'b0, 24'h0, 1'b1, acc);
        check("underrun_after_reset", 64'(underrun), 64'd1);
        tick(1'b0, 24'h0, 1'b0, acc);
        check("underrun_single_pulse", 64'(underrun), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
